// File: rtl/fft_sequencer.sv
// Radix-2 FFT address/bank sequencer driving two ping-pong dual-port RAMs.
// Define FFT_SEQ_STALL_EN to add a stall input that freezes sequencing.
module fft_sequencer #(
  parameter int N_2 = 11
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
`ifdef FFT_SEQ_STALL_EN
  input  logic           stall,
`endif
  output logic           busy,
  output logic           done,
  output logic           rdsel,
  output logic           we0,
  output logic           we1,
  output logic [N_2-1:0] adr0a,
  output logic [N_2-1:0] adr0b,
  output logic [N_2-1:0] adr1a,
  output logic [N_2-1:0] adr1b,
  output logic [N_2-2:0] twiddleadr,
  output logic           result_sel
);

  localparam int HW = N_2 - 1;
  localparam int SW = (N_2 > 1) ? $clog2(N_2) : 1;
  localparam logic [SW-1:0] SMAX = SW'(N_2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t         state;
  logic [SW-1:0]  s;
  logic [HW-1:0]  i;
  logic [N_2-1:0] pa;
  logic [N_2-1:0] pb;
  logic           wv;
  logic           hold;

`ifdef FFT_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  logic [N_2-1:0] ie;
  logic [N_2-1:0] mask;
  logic [N_2-1:0] lo;
  logic [N_2-1:0] hi;
  logic [N_2-1:0] adr_a;
  logic [N_2-1:0] adr_b;
  logic [HW-1:0]  tw;

  always_comb begin
    ie    = {1'b0, i};
    mask  = (N_2'(1) << s) - N_2'(1);
    lo    = ie & mask;
    hi    = ie >> s;
    adr_a = ((hi << s) << 1) | lo;
    adr_b = adr_a | (N_2'(1) << s);
    tw    = HW'(lo) << (SW'(HW) - s);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      i     <= '0;
      pa    <= '0;
      pb    <= '0;
      wv    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdsel <= 1'b0;
    end else if (!hold) begin
      wv   <= 1'b0;
      pa   <= '0;
      pb   <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            s     <= '0;
            i     <= '0;
            busy  <= 1'b1;
            rdsel <= 1'b0;
          end
        end
        RUN: begin
          wv <= 1'b1;
          pa <= adr_a;
          pb <= adr_b;
          i  <= i + 1'b1;
          if (i == '1) state <= DRAIN;
        end
        DRAIN: begin
          if (s == SMAX) begin
            state <= DONE;
            done  <= 1'b1;
            rdsel <= 1'b0;
          end else begin
            state <= RUN;
            s     <= s + 1'b1;
            i     <= '0;
            rdsel <= ~s[0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // read bank sees current butterfly, write bank the one issued last cycle
  logic           run;
  logic           act;
  logic [N_2-1:0] ra;
  logic [N_2-1:0] rb;
  logic [N_2-1:0] wa;
  logic [N_2-1:0] wb;

  always_comb begin
    run        = (state == RUN);
    act        = run || (state == DRAIN);
    ra         = run ? adr_a : '0;
    rb         = run ? adr_b : '0;
    wa         = act ? pa : '0;
    wb         = act ? pb : '0;
    adr0a      = rdsel ? wa : ra;
    adr0b      = rdsel ? wb : rb;
    adr1a      = rdsel ? ra : wa;
    adr1b      = rdsel ? rb : wb;
    twiddleadr = run ? tw : '0;
    we0        = wv & rdsel & ~hold;
    we1        = wv & ~rdsel & ~hold;
  end

  assign result_sel = ((N_2 - 1) % 2) == 0;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer at N_2=3 (8 points).
// Stall scenario is compiled in when FFT_SEQ_STALL_EN is defined.
module tb_fft_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic       rdsel;
  logic       we0;
  logic       we1;
  logic [2:0] adr0a;
  logic [2:0] adr0b;
  logic [2:0] adr1a;
  logic [2:0] adr1b;
  logic [1:0] twiddleadr;
  logic       result_sel;

  int checks = 0;
  int errors = 0;

  fft_sequencer #(.N_2(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
`ifdef FFT_SEQ_STALL_EN
    .stall      (stall),
`endif
    .busy       (busy),
    .done       (done),
    .rdsel      (rdsel),
    .we0        (we0),
    .we1        (we1),
    .adr0a      (adr0a),
    .adr0b      (adr0b),
    .adr1a      (adr1a),
    .adr1b      (adr1b),
    .twiddleadr (twiddleadr),
    .result_sel (result_sel)
  );

  always #5 clk = ~clk;

  int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // {rdsel,we0,we1,a0a,a0b,a1a,a1b,tw,busy,done}
  logic [18:0] obs;
  assign obs = {rdsel, we0, we1, adr0a, adr0b, adr1a, adr1b,
                twiddleadr, busy, done};

  task automatic run_seq(input string nm, input int st_from,
                         input int st_len, input int ms);
    int c;
    int st;
    int k;
    int idx;
    bit stl;
    logic       rs;
    logic       we;
    logic [2:0] ra, rb, wa, wb;
    logic [1:0] tw;
    logic       bz, dn;
    logic [18:0] exp_v;
    c = 0;
    start = 1'b1;
    for (int t = 0; t <= 16 + st_len; t++) begin
      @(posedge clk);
      #1;
      stl = (t >= st_from) && (t < st_from + st_len);
      start = (t == ms);
      stall = stl;
      #1;
      rs = 0; we = 0; ra = 0; rb = 0; wa = 0; wb = 0;
      tw = 0; bz = 0; dn = 0;
      if (c < 15) begin
        st = c / 5;
        k  = c % 5;
        rs = st[0];
        bz = 1;
        if (k < 4) begin
          idx = st * 4 + k;
          ra = 3'(ea[idx]);
          rb = 3'(eb[idx]);
          tw = 2'(et[idx]);
        end
        if (k > 0) begin
          idx = st * 4 + k - 1;
          wa = 3'(ea[idx]);
          wb = 3'(eb[idx]);
          we = !stl;
        end
      end else if (c == 15) begin
        bz = 1;
        dn = 1;
      end
      if (rs)
        exp_v = {rs, we, 1'b0, wa, wb, ra, rb, tw, bz, dn};
      else
        exp_v = {rs, 1'b0, we, ra, rb, wa, wb, tw, bz, dn};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d c=%0d: got %h expected %h",
                 nm, t, c, obs, exp_v);
      end
      if (!stl) c++;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    checks++;
    if (result_sel !== 1'b1) begin
      errors++;
      $display("FAIL result_sel: got %b expected 1", result_sel);
    end
    start = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL idle_no_start: got %h expected 0", obs);
    end
  endtask

  task automatic test_full;
    run_seq("full", 0, 0, -1);
  endtask

  task automatic test_back_to_back;
    run_seq("midstart", 0, 0, 3);
    run_seq("second", 0, 0, -1);
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (rdsel !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got rdsel=%b busy=%b expected 1 1",
               rdsel, busy);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_post: got %h expected 0", obs);
    end
    run_seq("after_reset", 0, 0, -1);
  endtask

`ifdef FFT_SEQ_STALL_EN
  task automatic test_stall;
    run_seq("stall", 2, 3, -1);
  endtask
`endif

  initial begin
    start = 1'b0;
    stall = 1'b0;
    reset_n = 1'b0;
    test_reset;
    test_full;
    test_back_to_back;
    test_reset_mid;
`ifdef FFT_SEQ_STALL_EN
    test_stall;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
